// File: rtl/regfile_param_if.sv
// Register-file port bundle: read indices/data, two write ports, collision flag.
// Latency: read side is combinational; the write side lands in storage one clock later.
// Backpressure: none; every read and write is accepted every cycle.
interface regfile_param_if #(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2
);
  logic [NUM_RD*ADDR_W-1:0] ReadRegister;
  logic [NUM_RD*DATA_W-1:0] ReadData;
  logic                     RegWrite0;
  logic [ADDR_W-1:0]        WriteRegister0;
  logic [DATA_W-1:0]        WriteData0;
  logic                     RegWrite1;
  logic [ADDR_W-1:0]        WriteRegister1;
  logic [DATA_W-1:0]        WriteData1;
  logic                     WriteConflict;

  // Pipeline side: issues reads and write-backs.
  modport master (
    output ReadRegister, RegWrite0, WriteRegister0, WriteData0,
           RegWrite1, WriteRegister1, WriteData1,
    input  ReadData, WriteConflict
  );

  // Register file side.
  modport slave (
    input  ReadRegister, RegWrite0, WriteRegister0, WriteData0,
           RegWrite1, WriteRegister1, WriteData1,
    output ReadData, WriteConflict
  );
endinterface

// File: rtl/regfile_param.sv
// Parametrised CPU register file: NUM_RD combinational read ports, two write ports, hardwired zero reg.
// Latency: reads 0 cycles (optional same-cycle write bypass); writes visible in storage after 1 edge.
// Backpressure: none; port 1 wins a same-index write collision, flagged on WriteConflict next cycle.
module regfile_param #(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 31,
  parameter int BYPASS   = 1
) (
  input  logic            clk,
  input  logic            reset,
  regfile_param_if.slave  rf
);

  logic [DATA_W-1:0]        mem_q [NUM_REGS];
  logic [DATA_W-1:0]        mem_d [NUM_REGS];
  logic                     conflict_q;
  logic                     conflict_d;
  logic                     wen0;
  logic                     wen1;
  logic [NUM_RD*DATA_W-1:0] rd_dat;

  // An index is writable when it exists and is not the hardwired zero register.
  function automatic logic writable(input logic [ADDR_W-1:0] a);
    return (int'(a) < NUM_REGS) && (int'(a) != ZERO_REG);
  endfunction

  assign wen0 = rf.RegWrite0 && writable(rf.WriteRegister0);
  assign wen1 = rf.RegWrite1 && writable(rf.WriteRegister1);

  // Next storage image: port 1 is checked first so it wins a same-index collision.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      mem_d[i] = mem_q[i];
      if (wen1 && (rf.WriteRegister1 == ADDR_W'(i))) begin
        mem_d[i] = rf.WriteData1;
      end else if (wen0 && (rf.WriteRegister0 == ADDR_W'(i))) begin
        mem_d[i] = rf.WriteData0;
      end
    end
    // A collision is flagged even when both ports hit the zero register.
    conflict_d = rf.RegWrite0 && rf.RegWrite1 && (rf.WriteRegister0 == rf.WriteRegister1);
  end

  // Storage and collision flag; reset clears everything and drops that cycle's writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
      conflict_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= mem_d[i];
      end
      conflict_q <= conflict_d;
    end
  end

  // Per-port read mux: zero/out-of-range reads give 0, bypass forwards this cycle's write data.
  always_comb begin : rd_mux
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    rd_dat = '0;
    ra     = '0;
    rd     = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra = rf.ReadRegister[k*ADDR_W +: ADDR_W];
      rd = '0;
      if (writable(ra)) begin
        rd = mem_q[ra];
        if ((BYPASS != 0) && !reset) begin
          if (wen1 && (rf.WriteRegister1 == ra)) begin
            rd = rf.WriteData1;
          end else if (wen0 && (rf.WriteRegister0 == ra)) begin
            rd = rf.WriteData0;
          end
        end
      end
      rd_dat[k*DATA_W +: DATA_W] = rd;
    end
  end

  assign rf.ReadData      = rd_dat;
  assign rf.WriteConflict = conflict_q;

endmodule

// File: tb/tb_regfile_param.sv
// Bench for two builds: A (64x32, 2 read ports, zero reg 31, bypass) and B (32x16, 3 ports, zero reg 0, no bypass).
// Latency: inputs change on the falling edge, reads sampled 2 time units later, model commits on the rising edge.
// Backpressure: not applicable; a write may be issued every cycle.
module tb_regfile_param;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  logic [63:0] ma [32];
  logic [63:0] mb [16];
  bit          conf_exp [2];

  regfile_param_if #(.DATA_W(64), .NUM_REGS(32), .ADDR_W(5), .NUM_RD(2)) ifa ();
  regfile_param_if #(.DATA_W(32), .NUM_REGS(16), .ADDR_W(4), .NUM_RD(3)) ifb ();

  regfile_param #(.DATA_W(64), .NUM_REGS(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(31), .BYPASS(1))
    dut_a (.clk(clk), .reset(reset), .rf(ifa));
  regfile_param #(.DATA_W(32), .NUM_REGS(16), .ADDR_W(4), .NUM_RD(3), .ZERO_REG(0), .BYPASS(0))
    dut_b (.clk(clk), .reset(reset), .rf(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference read: zero register reads 0; build A forwards a same-cycle write (port 1 first)
  // unless reset is high; otherwise the stored value.
  function automatic logic [63:0] exp_rd(input int cfg, input int r, input bit rst,
      input bit we0, input int a0, input logic [63:0] d0,
      input bit we1, input int a1, input logic [63:0] d1);
    int zr = (cfg == 0) ? 31 : 0;
    if (r == zr) return 64'd0;
    if (cfg == 0 && !rst) begin
      if (we1 && a1 == r) return d1;
      if (we0 && a0 == r) return d0;
    end
    return (cfg == 0) ? ma[r] : mb[r];
  endfunction

  // Reference storage update at the clock edge: writes applied in port order so port 1 lands last.
  function automatic void commit(input int cfg, input bit rst,
      input bit we0, input int a0, input logic [63:0] d0,
      input bit we1, input int a1, input logic [63:0] d1);
    int zr = (cfg == 0) ? 31 : 0;
    logic [63:0] m = (cfg == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    if (rst) begin
      for (int i = 0; i < 32; i++) ma[i] = 64'd0;
      for (int i = 0; i < 16; i++) mb[i] = 64'd0;
      conf_exp[0] = 1'b0;
      conf_exp[1] = 1'b0;
      return;
    end
    if (we0 && a0 != zr) begin
      if (cfg == 0) ma[a0] = d0 & m; else mb[a0] = d0 & m;
    end
    if (we1 && a1 != zr) begin
      if (cfg == 0) ma[a1] = d1 & m; else mb[a1] = d1 & m;
    end
    conf_exp[cfg] = we0 && we1 && (a0 == a1);
  endfunction

  // One clock cycle on build cfg: drive, check reads and conflict flag, then commit at the edge.
  task automatic step(input int cfg, input bit we0, input int a0, input logic [63:0] d0,
      input bit we1, input int a1, input logic [63:0] d1,
      input int r0, input int r1, input int r2);
    int          rr [3];
    int          nrd;
    logic [63:0] got;
    logic [63:0] dm0;
    logic [63:0] dm1;
    rr[0] = r0; rr[1] = r1; rr[2] = r2;
    nrd = (cfg == 0) ? 2 : 3;
    dm0 = (cfg == 0) ? d0 : (d0 & 64'hFFFF_FFFF);
    dm1 = (cfg == 0) ? d1 : (d1 & 64'hFFFF_FFFF);
    if (cfg == 0) begin
      ifa.RegWrite0 = we0; ifa.WriteRegister0 = 5'(a0); ifa.WriteData0 = d0;
      ifa.RegWrite1 = we1; ifa.WriteRegister1 = 5'(a1); ifa.WriteData1 = d1;
      ifa.ReadRegister = {5'(r1), 5'(r0)};
    end else begin
      ifb.RegWrite0 = we0; ifb.WriteRegister0 = 4'(a0); ifb.WriteData0 = 32'(d0);
      ifb.RegWrite1 = we1; ifb.WriteRegister1 = 4'(a1); ifb.WriteData1 = 32'(d1);
      ifb.ReadRegister = {4'(r2), 4'(r1), 4'(r0)};
    end
    #2;
    for (int k = 0; k < nrd; k++) begin
      got = (cfg == 0) ? ifa.ReadData[k*64 +: 64] : {32'd0, ifb.ReadData[k*32 +: 32]};
      chk($sformatf("c%0d_rd%0d_r%0d", cfg, k, rr[k]), got,
          exp_rd(cfg, rr[k], reset, we0, a0, dm0, we1, a1, dm1));
    end
    got = (cfg == 0) ? {63'd0, ifa.WriteConflict} : {63'd0, ifb.WriteConflict};
    chk($sformatf("c%0d_conflict", cfg), got, {63'd0, conf_exp[cfg]});
    @(posedge clk);
    commit(cfg, reset, we0, a0, dm0, we1, a1, dm1);
    @(negedge clk);
  endtask

  // Directed scenarios plus a randomized stretch for one build.
  task automatic run_cfg(input int cfg);
    int          nr = (cfg == 0) ? 32 : 16;
    int          zr = (cfg == 0) ? 31 : 0;
    logic [63:0] pat;
    // Cleared storage on every port.
    for (int i = 0; i < nr; i++) step(cfg, 0, 0, 0, 0, 0, 0, i, nr - 1 - i, (i + 3) % nr);
    // Writes to the zero register vanish.
    step(cfg, 1, zr, 64'hA0, 0, 0, 0, zr, zr, zr);
    step(cfg, 0, 0, 0, 1, zr, 64'hA1, zr, zr, zr);
    // Pattern fill through port 0, reading previous and current index.
    for (int i = 0; i < nr; i++) begin
      if (i == zr) continue;
      pat = 64'(i) * 64'h0000_0102_0408_0001;
      step(cfg, 1, i, pat, 0, 0, 0, (i + nr - 1) % nr, i, zr);
    end
    for (int i = 0; i < nr; i++) step(cfg, 0, 0, 0, 0, 0, 0, i, i, (i + 1) % nr);
    // Collision on reg 5, then flag drop; distinct indices store both.
    step(cfg, 1, 5, 64'h1111, 1, 5, 64'h2222, 5, 5, 5);
    step(cfg, 1, 8, 64'h8888, 1, 9, 64'h9999, 5, 8, 9);
    step(cfg, 0, 0, 0, 0, 0, 0, 8, 9, 5);
    step(cfg, 1, zr, 64'h3, 1, zr, 64'h4, 5, zr, 8);
    step(cfg, 0, 0, 0, 0, 0, 0, zr, 5, 9);
    // Same-cycle read of a register being written, then after the edge.
    step(cfg, 1, 7, 64'hDEAD, 0, 0, 0, 7, 6, 7);
    step(cfg, 0, 0, 0, 0, 0, 0, 7, 7, 7);
    // Reset mid-stream with a port 1 write to reg 3: no bypass, write dropped.
    reset = 1'b1;
    step(cfg, 0, 0, 0, 1, 3, 64'h3333, 3, 3, 3);
    reset = 1'b0;
    step(cfg, 0, 0, 0, 0, 0, 0, 3, 5, 7);
    // Randomized traffic with occasional resets; small address window encourages collisions.
    for (int n = 0; n < 300; n++) begin
      int hi = ($urandom_range(0, 3) == 0) ? 3 : nr - 1;
      reset = ($urandom_range(0, 39) == 0);
      step(cfg, bit'($urandom_range(0, 1)), $urandom_range(0, hi), {$urandom, $urandom},
           bit'($urandom_range(0, 1)), $urandom_range(0, hi), {$urandom, $urandom},
           $urandom_range(0, nr - 1), $urandom_range(0, hi), $urandom_range(0, nr - 1));
    end
    reset = 1'b0;
    step(cfg, 0, 0, 0, 0, 0, 0, 1, 2, 3);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    ifa.RegWrite0 = 1'b0; ifa.WriteRegister0 = '0; ifa.WriteData0 = '0;
    ifa.RegWrite1 = 1'b0; ifa.WriteRegister1 = '0; ifa.WriteData1 = '0;
    ifa.ReadRegister = '0;
    ifb.RegWrite0 = 1'b0; ifb.WriteRegister0 = '0; ifb.WriteData0 = '0;
    ifb.RegWrite1 = 1'b0; ifb.WriteRegister1 = '0; ifb.WriteData1 = '0;
    ifb.ReadRegister = '0;
    @(negedge clk);
    @(posedge clk);
    commit(0, 1'b1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    run_cfg(0);
    ifa.RegWrite0 = 1'b0;
    ifa.RegWrite1 = 1'b0;
    run_cfg(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
